regfile_nrw_bypass: RTL and testbench



---
 rtl/regfile_pkg.sv | 33 +++
 rtl/rf_read_port.sv | 55 +++++
 rtl/regfile_nrw_bypass.sv | 199 +++++++++++++++++++
 tb/tb_regfile_nrw_bypass.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file slice.
// Contents:
//   addr_w()            address width for a given register count
//   OP_LD / OP_ST       opcodes that use only one source operand
//   SRC2_ZERO_MASK_DEF  per-opcode mask of single-source opcodes
//   rf_wb_t             writeback record sized for the default configuration
package regfile_pkg;

    // Opcodes whose second source operand is meaningless.
    localparam logic [3:0] OP_LD = 4'b0100;
    localparam logic [3:0] OP_ST = 4'b0010;

    // Bit k set means opcode k carries only one source operand.
    localparam logic [15:0] SRC2_ZERO_MASK_DEF = (16'd1 << OP_LD) | (16'd1 << OP_ST);

    // Default geometry that the rf_wb_t record is sized for.
    localparam int RF_DEF_AW = 4;
    localparam int RF_DEF_DW = 8;

    // Address width for NUM_REGS registers.
    // Never returns less than one bit.
    function automatic int addr_w(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    // One writeback port's worth of information.
    typedef struct packed {
        logic                 vld;
        logic [RF_DEF_AW-1:0] des;
        logic [RF_DEF_DW-1:0] data;
    } rf_wb_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port with write-to-read bypass.
// Ports:
//   addr_i     register address to read
//   regs_i     current architectural register contents
//   wb_vld_i   writeback valids (port 0 has highest priority)
//   wb_des_i   writeback destinations
//   wb_data_i  writeback data
//   data_o     read result
//              - r0 and out-of-range addresses give 0
//              - otherwise the bypassed value or the register value
//   hit_o      a valid writeback targets this (nonzero, in-range) address
module rf_read_port #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 8,
    parameter int NUM_WB   = 4,
    parameter int AW       = 4
) (
    input  logic [AW-1:0]                    addr_i,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_i,
    input  logic [NUM_WB-1:0]                wb_vld_i,
    input  logic [NUM_WB-1:0][AW-1:0]        wb_des_i,
    input  logic [NUM_WB-1:0][DATA_W-1:0]    wb_data_i,
    output logic [DATA_W-1:0]                data_o,
    output logic                             hit_o
);

    logic              in_range;
    logic              match;
    logic [DATA_W-1:0] byp_data;

    // Find the winning writeback for this address.
    // The scan runs from the highest port down, so the lowest matching port
    // is the last to assign and therefore wins.
    // r0 and addresses past the end of the file never hit, since no write to
    // them can land.
    always_comb begin
        in_range = (addr_i != '0) && (32'(addr_i) < NUM_REGS);
        match    = 1'b0;
        byp_data = '0;
        for (int w = NUM_WB - 1; w >= 0; w--) begin
            if (wb_vld_i[w] && (wb_des_i[w] == addr_i)) begin
                match    = 1'b1;
                byp_data = wb_data_i[w];
            end
        end
        hit_o  = in_range && match;
        data_o = '0;
        if (hit_o) begin
            data_o = byp_data;
        end else if (in_range) begin
            data_o = regs_i[addr_i];
        end
    end

endmodule

// File: rtl/regfile_nrw_bypass.sv
// Multi-port architectural register file feeding a one-cycle issue/execute stage.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   in_*              per-channel issue fields
//                     valid, destination, sources, opcode, branch id, immediate
//   in_ready          upstream may advance (= ~out_stall)
//   out_stall         downstream cannot accept; the stage holds
//   back_*            NUM_WB writeback ports; port 0 wins on conflicts
//   out_*             registered issue fields and source operands
module regfile_nrw_bypass
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 8,
    parameter int NUM_RD   = 4,
    parameter int NUM_WB   = 4,
    parameter int OP_W     = 4,
    parameter int BID_W    = 3,
    parameter int IMM_W    = 4,
    parameter logic [2**OP_W-1:0] SRC2_ZERO_MASK = SRC2_ZERO_MASK_DEF,
    localparam int AW = addr_w(NUM_REGS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_RD-1:0]                 in_vld,
    input  logic [NUM_RD-1:0][AW-1:0]         in_des,
    input  logic [NUM_RD-1:0][AW-1:0]         in_s1,
    input  logic [NUM_RD-1:0][AW-1:0]         in_s2,
    input  logic [NUM_RD-1:0][OP_W-1:0]       in_op,
    input  logic [NUM_RD-1:0][BID_W-1:0]      in_branch,
    input  logic [NUM_RD-1:0][IMM_W-1:0]      in_ime,
    output logic                              in_ready,
    input  logic                              out_stall,
    input  logic [NUM_WB-1:0]                 back_vld,
    input  logic [NUM_WB-1:0][AW-1:0]         back_des,
    input  logic [NUM_WB-1:0][DATA_W-1:0]     back_data,
    output logic [NUM_RD-1:0]                 out_vld,
    output logic [NUM_RD-1:0][AW-1:0]         out_des,
    output logic [NUM_RD-1:0][OP_W-1:0]       out_op,
    output logic [NUM_RD-1:0][BID_W-1:0]      out_branch,
    output logic [NUM_RD-1:0][IMM_W-1:0]      out_ime,
    output logic [NUM_RD-1:0][DATA_W-1:0]     out_s1_data,
    output logic [NUM_RD-1:0][DATA_W-1:0]     out_s2_data
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;

    logic [NUM_RD-1:0]              vld_q, vld_d;
    logic [NUM_RD-1:0][AW-1:0]      des_q, des_d;
    logic [NUM_RD-1:0][OP_W-1:0]    op_q, op_d;
    logic [NUM_RD-1:0][BID_W-1:0]   br_q, br_d;
    logic [NUM_RD-1:0][IMM_W-1:0]   ime_q, ime_d;
    logic [NUM_RD-1:0][DATA_W-1:0]  s1_q, s1_d;
    logic [NUM_RD-1:0][DATA_W-1:0]  s2_q, s2_d;
    logic [NUM_RD-1:0][AW-1:0]      hold_s1_q, hold_s1_d;
    logic [NUM_RD-1:0][AW-1:0]      hold_s2_q, hold_s2_d;
    logic [NUM_RD-1:0]              hold_s2z_q, hold_s2z_d;

    logic [NUM_RD-1:0][AW-1:0]      rd_a1, rd_a2;
    logic [NUM_RD-1:0][DATA_W-1:0]  rd_d1, rd_d2;
    logic [NUM_RD-1:0]              rd_h1, rd_h2;

    assign in_ready = ~out_stall;

    // Register write.
    // Each register takes data from its lowest-index matching writeback port.
    // Scanning the ports downward gives that priority for free.
    // Entry 0 is kept permanently at zero.
    always_comb begin
        regs_d = regs_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int w = NUM_WB - 1; w >= 0; w--) begin
                if (back_vld[w] && (back_des[w] == AW'(r))) begin
                    regs_d[r] = back_data[w];
                end
            end
        end
        regs_d[0] = '0;
    end

    // Read-port addresses.
    // While stalled the same ports look up the held source addresses.
    // Their hit flags then say whether a writeback must refresh a held operand.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_a1[i] = out_stall ? hold_s1_q[i] : in_s1[i];
            rd_a2[i] = out_stall ? hold_s2_q[i] : in_s2[i];
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        rf_read_port #(
            .NUM_REGS (NUM_REGS),
            .DATA_W   (DATA_W),
            .NUM_WB   (NUM_WB),
            .AW       (AW)
        ) u_rd_s1 (
            .addr_i    (rd_a1[gi]),
            .regs_i    (regs_q),
            .wb_vld_i  (back_vld),
            .wb_des_i  (back_des),
            .wb_data_i (back_data),
            .data_o    (rd_d1[gi]),
            .hit_o     (rd_h1[gi])
        );
        rf_read_port #(
            .NUM_REGS (NUM_REGS),
            .DATA_W   (DATA_W),
            .NUM_WB   (NUM_WB),
            .AW       (AW)
        ) u_rd_s2 (
            .addr_i    (rd_a2[gi]),
            .regs_i    (regs_q),
            .wb_vld_i  (back_vld),
            .wb_des_i  (back_des),
            .wb_data_i (back_data),
            .data_o    (rd_d2[gi]),
            .hit_o     (rd_h2[gi])
        );
    end

    // Pipeline stage next state.
    // Free-running case: every channel loads, valid or not.
    // Stalled case: the fields hold, but operands of valid held channels
    // still absorb any writeback that targets their source.
    // A stalled operand is therefore current on release.
    always_comb begin
        vld_d      = vld_q;
        des_d      = des_q;
        op_d       = op_q;
        br_d       = br_q;
        ime_d      = ime_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        hold_s1_d  = hold_s1_q;
        hold_s2_d  = hold_s2_q;
        hold_s2z_d = hold_s2z_q;
        for (int i = 0; i < NUM_RD; i++) begin
            if (!out_stall) begin
                vld_d[i]      = in_vld[i];
                des_d[i]      = in_des[i];
                op_d[i]       = in_op[i];
                br_d[i]       = in_branch[i];
                ime_d[i]      = in_ime[i];
                hold_s1_d[i]  = in_s1[i];
                hold_s2_d[i]  = in_s2[i];
                hold_s2z_d[i] = SRC2_ZERO_MASK[in_op[i]];
                s1_d[i]       = rd_d1[i];
                s2_d[i]       = SRC2_ZERO_MASK[in_op[i]] ? '0 : rd_d2[i];
            end else if (vld_q[i]) begin
                if (rd_h1[i]) begin
                    s1_d[i] = rd_d1[i];
                end
                if (rd_h2[i] && !hold_s2z_q[i]) begin
                    s2_d[i] = rd_d2[i];
                end
            end
        end
    end

    // State registers.
    // Reset takes priority over both stall and writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q     <= '0;
            vld_q      <= '0;
            des_q      <= '0;
            op_q       <= '0;
            br_q       <= '0;
            ime_q      <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            hold_s1_q  <= '0;
            hold_s2_q  <= '0;
            hold_s2z_q <= '0;
        end else begin
            regs_q     <= regs_d;
            vld_q      <= vld_d;
            des_q      <= des_d;
            op_q       <= op_d;
            br_q       <= br_d;
            ime_q      <= ime_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            hold_s1_q  <= hold_s1_d;
            hold_s2_q  <= hold_s2_d;
            hold_s2z_q <= hold_s2z_d;
        end
    end

    assign out_vld     = vld_q;
    assign out_des     = des_q;
    assign out_op      = op_q;
    assign out_branch  = br_q;
    assign out_ime     = ime_q;
    assign out_s1_data = s1_q;
    assign out_s2_data = s2_q;

endmodule

// File: tb/tb_regfile_nrw_bypass.sv
// Self-checking bench for regfile_nrw_bypass (default parameters).
// Contents:
//   - Directed steps first, then a randomized phase.
//   - The reference model keeps an array of register values and the expected
//     stage contents.
//   - The model applies the writeback/read/stall rules directly with plain
//     loops.
module tb_regfile_nrw_bypass;
    import regfile_pkg::*;

    localparam int NR  = 4;
    localparam int NW  = 4;
    localparam int WBW = $bits(rf_wb_t);

    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0]        in_vld;
    logic [NR-1:0][3:0]   in_des, in_s1, in_s2, in_op, in_ime;
    logic [NR-1:0][2:0]   in_branch;
    logic                 in_ready;
    logic                 out_stall;
    logic [NW-1:0]        back_vld;
    logic [NW-1:0][3:0]   back_des;
    logic [NW-1:0][7:0]   back_data;
    logic [NR-1:0]        out_vld;
    logic [NR-1:0][3:0]   out_des, out_op, out_ime;
    logic [NR-1:0][2:0]   out_branch;
    logic [NR-1:0][7:0]   out_s1_data, out_s2_data;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] mReg [16];
    logic       expVld [NR];
    logic [3:0] expDes [NR];
    logic [3:0] expOp  [NR];
    logic [3:0] expIme [NR];
    logic [2:0] expBr  [NR];
    logic [7:0] expS1  [NR];
    logic [7:0] expS2  [NR];
    logic [3:0] hS1    [NR];
    logic [3:0] hS2    [NR];
    logic       hS2z   [NR];

    always #5 clk = ~clk;

    regfile_nrw_bypass dut (
        .clk         (clk),
        .rst         (rst),
        .in_vld      (in_vld),
        .in_des      (in_des),
        .in_s1       (in_s1),
        .in_s2       (in_s2),
        .in_op       (in_op),
        .in_branch   (in_branch),
        .in_ime      (in_ime),
        .in_ready    (in_ready),
        .out_stall   (out_stall),
        .back_vld    (back_vld),
        .back_des    (back_des),
        .back_data   (back_data),
        .out_vld     (out_vld),
        .out_des     (out_des),
        .out_op      (out_op),
        .out_branch  (out_branch),
        .out_ime     (out_ime),
        .out_s1_data (out_s1_data),
        .out_s2_data (out_s2_data)
    );

    // Index of the writeback port that wins register a, or -1.
    function automatic int winPort(input logic [3:0] a);
        for (int w = 0; w < NW; w++) begin
            if (back_vld[w] && back_des[w] == a) return w;
        end
        return -1;
    endfunction

    // Value an issue-stage read of register a sees this cycle.
    function automatic logic [7:0] mRead(input logic [3:0] a);
        int wp;
        if (a == 4'd0) return 8'h00;
        wp = winPort(a);
        if (wp >= 0) return back_data[wp];
        return mReg[a];
    endfunction

    // Loads and stores use only their first source operand.
    function automatic logic singleSrc(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    // Predict the state after the coming clock edge from the current inputs.
    task automatic modelStep();
        logic [7:0] nReg [16];
        int wp;
        if (rst) begin
            for (int r = 0; r < 16; r++) mReg[r] = 8'h00;
            for (int i = 0; i < NR; i++) begin
                expVld[i] = 1'b0; expDes[i] = '0; expOp[i] = '0;
                expIme[i] = '0;   expBr[i]  = '0; expS1[i] = '0;
                expS2[i]  = '0;   hS1[i]    = '0; hS2[i]   = '0;
                hS2z[i]   = 1'b0;
            end
            return;
        end
        nReg = mReg;
        for (int r = 1; r < 16; r++) begin
            wp = winPort(4'(r));
            if (wp >= 0) nReg[r] = back_data[wp];
        end
        for (int i = 0; i < NR; i++) begin
            if (!out_stall) begin
                expVld[i] = in_vld[i];
                expDes[i] = in_des[i];
                expOp[i]  = in_op[i];
                expIme[i] = in_ime[i];
                expBr[i]  = in_branch[i];
                hS1[i]    = in_s1[i];
                hS2[i]    = in_s2[i];
                hS2z[i]   = singleSrc(in_op[i]);
                expS1[i]  = mRead(in_s1[i]);
                expS2[i]  = hS2z[i] ? 8'h00 : mRead(in_s2[i]);
            end else if (expVld[i]) begin
                if (hS1[i] != 4'd0) begin
                    wp = winPort(hS1[i]);
                    if (wp >= 0) expS1[i] = back_data[wp];
                end
                if (hS2[i] != 4'd0 && !hS2z[i]) begin
                    wp = winPort(hS2[i]);
                    if (wp >= 0) expS2[i] = back_data[wp];
                end
            end
        end
        mReg = nReg;
    endtask

    // Single comparison point.
    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock with the current inputs.
    // The model step happens before the edge; sampling is on the next falling edge.
    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compare every output against the model.
    task automatic checkOutput();
        checkEq("in_ready", 32'(in_ready), 32'(!out_stall));
        for (int i = 0; i < NR; i++) begin
            checkEq($sformatf("out_vld[%0d]", i),     32'(out_vld[i]),     32'(expVld[i]));
            checkEq($sformatf("out_des[%0d]", i),     32'(out_des[i]),     32'(expDes[i]));
            checkEq($sformatf("out_op[%0d]", i),      32'(out_op[i]),      32'(expOp[i]));
            checkEq($sformatf("out_branch[%0d]", i),  32'(out_branch[i]),  32'(expBr[i]));
            checkEq($sformatf("out_ime[%0d]", i),     32'(out_ime[i]),     32'(expIme[i]));
            checkEq($sformatf("out_s1_data[%0d]", i), 32'(out_s1_data[i]), 32'(expS1[i]));
            checkEq($sformatf("out_s2_data[%0d]", i), 32'(out_s2_data[i]), 32'(expS2[i]));
        end
    endtask

    // Quiet every input except reset and stall.
    task automatic clearInputs();
        in_vld = '0; in_des = '0; in_s1 = '0; in_s2 = '0;
        in_op = '0; in_branch = '0; in_ime = '0;
        back_vld = '0; back_des = '0; back_data = '0;
    endtask

    // Fill the issue and writeback inputs with random values.
    task automatic randomInputs();
        rf_wb_t wb;
        for (int i = 0; i < NR; i++) begin
            in_vld[i]    = 1'($urandom);
            in_des[i]    = 4'($urandom);
            in_s1[i]     = 4'($urandom);
            in_s2[i]     = 4'($urandom);
            in_op[i]     = 4'($urandom);
            in_branch[i] = 3'($urandom);
            in_ime[i]    = 4'($urandom);
        end
        for (int w = 0; w < NW; w++) begin
            wb           = rf_wb_t'(WBW'($urandom));
            back_vld[w]  = wb.vld;
            back_des[w]  = wb.des;
            back_data[w] = wb.data;
        end
    endtask

    initial begin
        // Reset
        clearInputs();
        rst = 1'b1;
        out_stall = 1'b0;
        applyStimulus();
        checkOutput();
        checkEq("reset_out_vld", 32'(out_vld), 32'h0);
        rst = 1'b0;

        // First read after reset sees zeros, one cycle later
        clearInputs();
        in_vld[0] = 1'b1; in_s1[0] = 4'd3; in_s2[0] = 4'd5; in_op[0] = 4'd0;
        in_des[0] = 4'd6; in_branch[0] = 3'd5; in_ime[0] = 4'hC;
        applyStimulus();
        checkOutput();
        checkEq("tp1_vld0", 32'(out_vld[0]), 32'h1);

        // Writeback to r3 bypassed into channel 1 in the same cycle
        clearInputs();
        back_vld[0] = 1'b1; back_des[0] = 4'd3; back_data[0] = 8'hA5;
        in_vld[1] = 1'b1; in_s1[1] = 4'd3;
        applyStimulus();
        checkOutput();
        checkEq("tp2_bypass", 32'(out_s1_data[1]), 32'hA5);
        clearInputs();
        in_vld[0] = 1'b1; in_s1[0] = 4'd3;
        applyStimulus();
        checkOutput();
        checkEq("tp2_regread", 32'(out_s1_data[0]), 32'hA5);

        // Port priority on r7, write to r0 ignored
        clearInputs();
        back_vld[0] = 1'b1; back_des[0] = 4'd7; back_data[0] = 8'h11;
        back_vld[2] = 1'b1; back_des[2] = 4'd7; back_data[2] = 8'h22;
        back_vld[3] = 1'b1; back_des[3] = 4'd0; back_data[3] = 8'hFF;
        applyStimulus();
        checkOutput();
        clearInputs();
        in_vld[0] = 1'b1; in_s1[0] = 4'd7; in_s2[0] = 4'd0;
        in_vld[3] = 1'b1; in_s1[3] = 4'd7; in_s2[3] = 4'd7;
        applyStimulus();
        checkOutput();
        checkEq("tp3_r7", 32'(out_s1_data[0]), 32'h11);
        checkEq("tp3_r0", 32'(out_s2_data[0]), 32'h00);
        checkEq("s1_eq_s2", 32'(out_s2_data[3]), 32'h11);

        // All ports hitting r5 together: port 0 wins
        clearInputs();
        for (int w = 0; w < NW; w++) begin
            back_vld[w] = 1'b1; back_des[w] = 4'd5; back_data[w] = 8'(8'h30 + w);
        end
        in_vld[1] = 1'b1; in_s2[1] = 4'd5;
        applyStimulus();
        checkOutput();
        checkEq("all_ports_r5", 32'(out_s2_data[1]), 32'h30);

        // Load opcode forces s2 to zero
        clearInputs();
        in_vld[2] = 1'b1; in_op[2] = OP_LD; in_s1[2] = 4'd7; in_s2[2] = 4'd3;
        applyStimulus();
        checkOutput();
        checkEq("ld_s2_zero", 32'(out_s2_data[2]), 32'h00);
        checkEq("ld_s1", 32'(out_s1_data[2]), 32'h11);

        // Stall on channel 0 holding r9
        clearInputs();
        back_vld[1] = 1'b1; back_des[1] = 4'd9; back_data[1] = 8'h01;
        applyStimulus();
        checkOutput();
        clearInputs();
        in_vld[0] = 1'b1; in_s1[0] = 4'd9; in_op[0] = 4'd1; in_des[0] = 4'd2;
        applyStimulus();
        checkOutput();
        checkEq("stall_pre", 32'(out_s1_data[0]), 32'h01);
        out_stall = 1'b1;
        randomInputs();
        back_vld = '0;
        applyStimulus();
        checkOutput();
        randomInputs();
        back_vld = '0;
        back_vld[1] = 1'b1; back_des[1] = 4'd9; back_data[1] = 8'h42;
        applyStimulus();
        checkOutput();
        checkEq("stall_capture", 32'(out_s1_data[0]), 32'h42);
        checkEq("stall_ready", 32'(in_ready), 32'h0);
        randomInputs();
        back_vld = '0;
        applyStimulus();
        checkOutput();
        checkEq("stall_hold_des", 32'(out_des[0]), 32'h2);
        out_stall = 1'b0;
        clearInputs();
        in_vld[1] = 1'b1; in_s1[1] = 4'd9;
        applyStimulus();
        checkOutput();
        checkEq("release_r9", 32'(out_s1_data[1]), 32'h42);

        // Reset during a stall with a writeback pending
        out_stall = 1'b1;
        randomInputs();
        back_vld[0] = 1'b1; back_des[0] = 4'd9; back_data[0] = 8'h77;
        rst = 1'b1;
        applyStimulus();
        checkOutput();
        checkEq("rst_stall_vld", 32'(out_vld), 32'h0);
        checkEq("rst_stall_s1", 32'(out_s1_data), 32'h0);
        rst = 1'b0;
        out_stall = 1'b0;
        clearInputs();
        in_vld[0] = 1'b1; in_s1[0] = 4'd9; in_s2[0] = 4'd3;
        applyStimulus();
        checkOutput();
        checkEq("rst_r9", 32'(out_s1_data[0]), 32'h00);
        checkEq("rst_r3", 32'(out_s2_data[0]), 32'h00);

        // Randomized phase with stall toggling and occasional reset
        for (int n = 0; n < 400; n++) begin
            randomInputs();
            out_stall = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 59) == 0);
            applyStimulus();
            checkOutput();
        end
        rst = 1'b0;
        out_stall = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
